// File: rtl/vx_ag_tcu_uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vx_ag_tcu_uop_sequencer
// Brief    : Expands one macro tile-MMA request into an M x N grid of micro-ops,
//            tracks results in flight and pulses completion when all retire.
// Revision : 1.0
// ============================================================================
module vx_ag_tcu_uop_sequencer #(
  parameter int NUM_M_STEPS     = 2,
  parameter int NUM_N_STEPS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int UUID_W          = 44,
  parameter int NW_W            = 2,
  parameter int PC_W            = 30,
  parameter int RD_W            = 6
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [UUID_W-1:0] req_uuid,
  input  logic [NW_W-1:0]   req_wid,
  input  logic [PC_W-1:0]   req_PC,
  input  logic [RD_W-1:0]   req_rd,
  input  logic [3:0]        req_fmt_s,
  input  logic [3:0]        req_fmt_d,
  input  logic [8:0]        req_scale,

  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [UUID_W-1:0] uop_uuid,
  output logic [NW_W-1:0]   uop_wid,
  output logic [PC_W-1:0]   uop_PC,
  output logic [RD_W-1:0]   uop_rd,
  output logic [3:0]        uop_step_m,
  output logic [3:0]        uop_step_n,
  output logic [3:0]        uop_fmt_s,
  output logic [3:0]        uop_fmt_d,
  output logic [8:0]        scale_combined,

  input  logic              res_fire,
  output logic              done_valid,
  output logic [UUID_W-1:0] done_uuid,
  output logic [NW_W-1:0]   done_wid,
  output logic              busy
);

  localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [3:0]         c_LAST_M   = 4'(NUM_M_STEPS - 1);
  localparam logic [3:0]         c_LAST_N   = 4'(NUM_N_STEPS - 1);
  localparam logic [c_OUT_W-1:0] c_MAX_OUT  = c_OUT_W'(MAX_OUTSTANDING);
  localparam logic [c_OUT_W-1:0] c_OUT_ONE  = c_OUT_W'(1);
  localparam logic [RD_W-1:0]    c_N_RD     = RD_W'(NUM_N_STEPS);

  logic [1:0]         r_state;
  logic [3:0]         r_m;
  logic [3:0]         r_n;
  logic [c_OUT_W-1:0] r_outstanding;
  logic [UUID_W-1:0]  r_uuid;
  logic [NW_W-1:0]    r_wid;
  logic [PC_W-1:0]    r_pc;
  logic [RD_W-1:0]    r_rd;
  logic [3:0]         r_fmt_s;
  logic [3:0]         r_fmt_d;
  logic [8:0]         r_scale;
  logic               r_done_valid;

  logic w_req_fire;
  logic w_uop_fire;

  assign req_ready  = (r_state == c_IDLE);
  assign w_req_fire = req_valid && req_ready;
  assign uop_valid  = (r_state == c_ISSUE) && (r_outstanding < c_MAX_OUT);
  assign w_uop_fire = uop_valid && uop_ready;

  assign uop_uuid       = r_uuid;
  assign uop_wid        = r_wid;
  assign uop_PC         = r_pc;
  assign uop_step_m     = r_m;
  assign uop_step_n     = r_n;
  assign uop_fmt_s      = r_fmt_s;
  assign uop_fmt_d      = r_fmt_d;
  assign scale_combined = r_scale;

  // Register offset is computed modulo 2^RD_W, so truncating operands first is exact.
  assign uop_rd = r_rd + RD_W'(r_m) * c_N_RD + RD_W'(r_n);

  assign done_valid = r_done_valid;
  assign done_uuid  = r_uuid;
  assign done_wid   = r_wid;
  assign busy       = (r_state != c_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_m          <= '0;
      r_n          <= '0;
      r_uuid       <= '0;
      r_wid        <= '0;
      r_pc         <= '0;
      r_rd         <= '0;
      r_fmt_s      <= '0;
      r_fmt_d      <= '0;
      r_scale      <= '0;
      r_done_valid <= 1'b0;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_req_fire) begin
            r_uuid  <= req_uuid;
            r_wid   <= req_wid;
            r_pc    <= req_PC;
            r_rd    <= req_rd;
            r_fmt_s <= req_fmt_s;
            r_fmt_d <= req_fmt_d;
            r_scale <= req_scale;
            r_m     <= '0;
            r_n     <= '0;
            r_state <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          if (w_uop_fire) begin
            if (r_n == c_LAST_N) begin
              r_n <= '0;
              if (r_m == c_LAST_M) begin
                r_m     <= '0;
                r_state <= c_DRAIN;
              end else begin
                r_m <= r_m + 4'd1;
              end
            end else begin
              r_n <= r_n + 4'd1;
            end
          end
        end
        c_DRAIN: begin
          if (r_outstanding == '0) begin
            r_state      <= c_IDLE;
            r_done_valid <= 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // A stray result with nothing in flight saturates at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_uop_fire, res_fire})
        2'b10:   r_outstanding <= r_outstanding + c_OUT_ONE;
        2'b01: begin
          if (r_outstanding != '0) begin
            r_outstanding <= r_outstanding - c_OUT_ONE;
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_result_underflow: assert property (@(posedge clk) disable iff (reset)
    !(res_fire && (r_outstanding == '0)));
`endif

endmodule
`default_nettype wire
